fe_mul_arbiter: RTL and testbench

- Shares one field multiplier (320-bit limb form, `valid`/`done` pulse handshake) among NREQ requesters.
- Typical requesters: ge_frombytes_negate_vartime, fe_pow22523, point add/double sequencers.
- Each requester sees a private multiplier port with the same pulse protocol.
- Grants are round-robin, one multiplication in flight at a time.
- Sits between the ge_* controllers and the single fe_mul instance in the top level.

---
 rtl/fe_mul_arbiter_pkg.sv | 17 +
 rtl/fe_mul_arbiter_if.sv | 28 ++
 rtl/fe_mul_arbiter_rr_pick.sv | 29 ++
 rtl/fe_mul_arbiter.sv | 126 ++++++++++++
 tb/tb_fe_mul_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fe_mul_arbiter_pkg.sv
// Shared constants, state encoding and index helper for the field-multiplier arbiter.
package fe_mul_arbiter_pkg;

    localparam int unsigned FE_W_DEF = 320;
    localparam int unsigned NREQ_MIN = 2;
    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fe_mul_arbiter_if.sv
// Requester-side and multiplier-side bus of the shared fe_mul arbiter.
interface fe_mul_arbiter_if
    import fe_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned FE_W = FE_W_DEF
);
    logic [NREQ*FE_W-1:0] req_op_a;
    logic [NREQ*FE_W-1:0] req_op_b;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_done;
    logic [FE_W-1:0]      req_res;
    logic [FE_W-1:0]      mul_op_a;
    logic [FE_W-1:0]      mul_op_b;
    logic                 mul_valid;
    logic [FE_W-1:0]      mul_res;
    logic                 mul_done;

    modport master (
        input  req_op_a, req_op_b, req_valid, mul_res, mul_done,
        output req_done, req_res, mul_op_a, mul_op_b, mul_valid
    );

    modport slave (
        output req_op_a, req_op_b, req_valid, mul_res, mul_done,
        input  req_done, req_res, mul_op_a, mul_op_b, mul_valid
    );
endinterface

// File: rtl/fe_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after rr_ptr, wrapping.
module fe_rr_pick
    import fe_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);
    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            int unsigned idx;
            idx = 32'(rr_ptr) + k - 1;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (pending[idx]) begin
                grant_idx = IDX_W'(idx);
                grant_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fe_mul_arbiter.sv
// Shares one pulse-handshake field multiplier among NREQ requesters, round-robin,
// one multiplication in flight.
module fe_mul_arbiter
    import fe_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned FE_W = FE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fe_mul_arbiter_if.master bus,
    output logic             busy,
    output logic             err
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  pending_q, pending_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  req_done_q, req_done_d;
    logic [FE_W-1:0]  req_res_q, req_res_d;
    logic [FE_W-1:0]  mul_op_a_q, mul_op_a_d;
    logic [FE_W-1:0]  mul_op_b_q, mul_op_b_d;
    logic             mul_valid_q, mul_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [NREQ-1:0]  owner_mask;
    logic [NREQ-1:0]  grant_mask;
    logic [NREQ-1:0]  dup_req;

    fe_rr_pick #(.NREQ(NREQ)) u_pick (
        .pending   (pending_q),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        owner_mask = '0;
        owner_mask[owner_q] = 1'b1;
        grant_mask = '0;
        if (state_q == ST_IDLE && grant_any) begin
            grant_mask[grant_idx] = 1'b1;
        end
        // A repeat request from a port already queued or in service is merged, not re-queued.
        dup_req = bus.req_valid & (pending_q | ((state_q == ST_WAIT) ? owner_mask : '0));

        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        req_done_d  = '0;
        req_res_d   = req_res_q;
        mul_op_a_d  = mul_op_a_q;
        mul_op_b_d  = mul_op_b_q;
        mul_valid_d = 1'b0;
        err_d       = err_q | (|dup_req);
        pending_d   = (pending_q | (bus.req_valid & ~dup_req)) & ~grant_mask;

        case (state_q)
            ST_IDLE: begin
                if (bus.mul_done) begin
                    err_d = 1'b1;
                end
                if (grant_any) begin
                    owner_d     = grant_idx;
                    mul_op_a_d  = bus.req_op_a[grant_idx*FE_W +: FE_W];
                    mul_op_b_d  = bus.req_op_b[grant_idx*FE_W +: FE_W];
                    mul_valid_d = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done coincident with our own start pulse cannot belong to it.
                if (bus.mul_done && !mul_valid_q) begin
                    req_res_d  = bus.mul_res;
                    req_done_d = owner_mask;
                    rr_ptr_d   = IDX_W'(wrap_inc(32'(owner_q), NREQ));
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_q == ST_WAIT) | (|pending_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            req_done_q  <= '0;
            req_res_q   <= '0;
            mul_op_a_q  <= '0;
            mul_op_b_q  <= '0;
            mul_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            req_done_q  <= req_done_d;
            req_res_q   <= req_res_d;
            mul_op_a_q  <= mul_op_a_d;
            mul_op_b_q  <= mul_op_b_d;
            mul_valid_q <= mul_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_done  = req_done_q;
    assign bus.req_res   = req_res_q;
    assign bus.mul_op_a  = mul_op_a_q;
    assign bus.mul_op_b  = mul_op_b_q;
    assign bus.mul_valid = mul_valid_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Scoreboard bench for fe_mul_arbiter: directed requests, 5-cycle multiplier model,
// monitor popping expected operands and completions.
module tb_fe_mul_arbiter;
    import fe_mul_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned FE_W = 320;
    localparam int unsigned LAT  = 5;

    typedef logic [FE_W-1:0] fe_t;
    typedef struct { logic [NREQ-1:0] done; fe_t res; } done_exp_t;
    typedef struct { fe_t a; fe_t b; bit b2b; } mul_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, err;

    fe_mul_arbiter_if #(.NREQ(NREQ), .FE_W(FE_W)) bus ();

    fe_mul_arbiter #(.NREQ(NREQ), .FE_W(FE_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    done_exp_t   done_q[$];
    mul_exp_t    mul_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_done_cyc = 0;
    int unsigned inj_cnt = 0;
    fe_t         inj_val = '0;

    function automatic void check(input string name, input fe_t act, input fe_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Multiplier model: product LAT cycles after the start pulse; cancelled by reset.
    fe_t         m_a, m_b;
    int unsigned m_cnt = 0;
    int unsigned inj_seen = 0;
    always @(negedge clk) begin
        bus.mul_done = 1'b0;
        if (!rst) begin
            m_cnt = 0;
            bus.mul_res = '0;
        end else begin
            if (bus.mul_valid) begin
                m_a = bus.mul_op_a;
                m_b = bus.mul_op_b;
                m_cnt = LAT;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_res = m_a * m_b;
                end
            end
            if (inj_cnt != inj_seen) begin
                inj_seen = inj_cnt;
                bus.mul_done = 1'b1;
                bus.mul_res = inj_val;
            end
        end
    end

    // Monitor: every start pulse and every completion must match the head of its queue.
    always @(negedge clk) begin
        done_exp_t de;
        mul_exp_t  me;
        cyc++;
        if (|bus.req_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_req_done", fe_t'(bus.req_done), '0);
            end else begin
                de = done_q.pop_front();
                check("req_done", fe_t'(bus.req_done), fe_t'(de.done));
                check("req_res", bus.req_res, de.res);
            end
            last_done_cyc = cyc;
        end
        if (bus.mul_valid) begin
            if (mul_q.size() == 0) begin
                check("unexpected_mul_valid", fe_t'(bus.mul_valid), '0);
            end else begin
                me = mul_q.pop_front();
                check("mul_op_a", bus.mul_op_a, me.a);
                check("mul_op_b", bus.mul_op_b, me.b);
                if (me.b2b) begin
                    check("b2b_gap", fe_t'(cyc - last_done_cyc), fe_t'(1));
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_op(input int unsigned p, input fe_t a, input fe_t b);
        bus.req_op_a[p*FE_W +: FE_W] = a;
        bus.req_op_b[p*FE_W +: FE_W] = b;
    endtask

    task automatic expect_txn(input int unsigned p, input fe_t a, input fe_t b, input bit b2b, input fe_t prod);
        mul_exp_t  me;
        done_exp_t de;
        me.a = a; me.b = b; me.b2b = b2b;
        de.done = '0; de.done[p] = 1'b1; de.res = prod;
        mul_q.push_back(me);
        done_q.push_back(de);
    endtask

    task automatic pulse(input logic [NREQ-1:0] m);
        @(negedge clk);
        bus.req_valid = m;
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d);
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (|bus.req_done) begin
                d = bus.req_done;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL done_timeout: got no req_done expected one within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && done_q.size() == 0 && mul_q.size() == 0) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL idle_timeout: got busy=%0b pending_exp=%0d expected idle", busy, done_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] d;
        bus.req_valid = '0;
        bus.req_op_a  = '0;
        bus.req_op_b  = '0;
        tick(3);
        check("rst_req_done", fe_t'(bus.req_done), '0);
        check("rst_req_res", bus.req_res, '0);
        check("rst_mul_op_a", bus.mul_op_a, '0);
        check("rst_mul_op_b", bus.mul_op_b, '0);
        check("rst_mul_valid", fe_t'(bus.mul_valid), '0);
        check("rst_busy", fe_t'(busy), '0);
        check("rst_err", fe_t'(err), '0);
        rst = 1'b1;

        // Single request on port 2: start pulse in the cycle after the grant edge.
        set_op(2, 2, 3);
        expect_txn(2, 2, 3, 0, 6);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        check("t1_mv_not_yet", fe_t'(bus.mul_valid), '0);
        @(negedge clk);
        check("t1_mv_latency", fe_t'(bus.mul_valid), fe_t'(1));
        wait_idle();

        // rr_ptr is now 3: port 3 wins over port 0.
        set_op(0, 6, 7);
        set_op(3, 8, 9);
        expect_txn(3, 8, 9, 0, 72);
        expect_txn(0, 6, 7, 1, 42);
        pulse(4'b1001);
        wait_idle();

        // Simultaneous 1011 from rr_ptr=0: order 0,1,3, back-to-back.
        do_reset();
        set_op(0, 7, 11);
        set_op(1, 13, 17);
        set_op(3, 100, 200);
        expect_txn(0, 7, 11, 0, 77);
        expect_txn(1, 13, 17, 1, 221);
        expect_txn(3, 100, 200, 1, 20000);
        pulse(4'b1011);
        wait_done(d);
        wait_done(d);
        wait_done(d);
        check("t2_last_owner", fe_t'(d), fe_t'(4'b1000));
        check("t2_busy_at_done", fe_t'(busy), fe_t'(1));
        tick(1);
        check("t2_busy_after", fe_t'(busy), '0);
        wait_idle();

        // Fairness: ports 0 and 1 re-request on every done; owners must alternate.
        set_op(0, 1, 3);
        set_op(1, 2, 5);
        expect_txn(0, 1, 3, 0, 3);
        expect_txn(1, 2, 5, 1, 10);
        pulse(4'b0011);
        for (int unsigned k = 2; k < 20; k++) begin
            int unsigned p;
            fe_t a, b;
            wait_done(d);
            if (d == '0) break;
            p = d[0] ? 0 : 1;
            a = fe_t'(k + 1);
            b = (p == 0) ? fe_t'(3) : fe_t'(5);
            set_op(p, a, b);
            expect_txn(p, a, b, 1, a * b);
            bus.req_valid = d;
            @(negedge clk);
            bus.req_valid = '0;
        end
        wait_idle();
        check("err_clean", fe_t'(err), '0);

        // Duplicate while pending: port 2 pulses twice while port 0 is in service.
        set_op(0, 3, 3);
        set_op(2, 4, 4);
        expect_txn(0, 3, 3, 0, 9);
        expect_txn(2, 4, 4, 1, 16);
        pulse(4'b0001);
        tick(2);
        pulse(4'b0100);
        pulse(4'b0100);
        wait_idle();
        tick(5);
        check("t4a_err", fe_t'(err), fe_t'(1));

        // Duplicate from the owner while in service.
        do_reset();
        check("err_after_reset", fe_t'(err), '0);
        set_op(1, 9, 9);
        expect_txn(1, 9, 9, 0, 81);
        pulse(4'b0010);
        tick(3);
        pulse(4'b0010);
        wait_idle();
        tick(5);
        check("t4b_err", fe_t'(err), fe_t'(1));
        tick(10);
        check("t4b_err_sticky", fe_t'(err), fe_t'(1));

        // Spurious done in IDLE: flagged, result untouched, no completion.
        do_reset();
        set_op(3, 5, 5);
        expect_txn(3, 5, 5, 0, 25);
        pulse(4'b1000);
        wait_idle();
        check("t5_err_before", fe_t'(err), '0);
        @(posedge clk);
        #1;
        inj_val = 999;
        inj_cnt++;
        tick(4);
        check("t5_err", fe_t'(err), fe_t'(1));
        check("t5_res_kept", bus.req_res, fe_t'(25));

        // Reset mid-operation, then a late done.
        set_op(0, 4, 4);
        begin
            mul_exp_t me;
            me.a = 4; me.b = 4; me.b2b = 0;
            mul_q.push_back(me);
        end
        pulse(4'b0001);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("t6_req_done", fe_t'(bus.req_done), '0);
        check("t6_req_res", bus.req_res, '0);
        check("t6_mul_op_a", bus.mul_op_a, '0);
        check("t6_mul_valid", fe_t'(bus.mul_valid), '0);
        check("t6_busy", fe_t'(busy), '0);
        check("t6_err", fe_t'(err), '0);
        rst = 1'b1;
        tick(2);
        @(posedge clk);
        #1;
        inj_val = 16;
        inj_cnt++;
        tick(4);
        check("t6_late_err", fe_t'(err), fe_t'(1));
        check("t6_late_res", bus.req_res, '0);

        wait_idle();
        check("done_q_drained", fe_t'(done_q.size()), '0);
        check("mul_q_drained", fe_t'(mul_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
